ahb_matrix_output_arb: RTL and testbench

AHB_MATRIX_OUTPUT_ARB -- requirements
Module: ahb_matrix_output_arb

---
 rtl/ahb_matrix_output_arb.sv | 209 ++++++++++++++++++++
 tb/tb_ahb_matrix_output_arb.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_matrix_output_arb.sv
// ---------------------------------------------------------------------------
// ahb_matrix_output_arb
// Output-stage arbiter of a 2-input AHB matrix. It picks which input port owns
// the address phase of this slave output, multiplexes that port's address and
// control onto the slave bus, and tracks the data phase owner so write data
// follows one cycle behind the address.
//
// Ports
//   HCLK, HRESETn                 clock, asynchronous active-low reset
//   sel_op0/1, addr_op0/1,        per-port select from the port decoder plus
//   trans/write/size/burst/prot   the port's address-phase control
//   wdata_op0/1                   per-port write data (data phase)
//   HREADYOUTM                    slave HREADYOUT
//   active_op0/1                  port N owns this output's address phase
//   HSELM..HPROTM                 slave address phase
//   HWDATAM                       slave write data
//   HREADYMUXM                    HREADY returned to the slave
//
// Configuration
//   AHB_MATRIX_OUTPUT_ARB_FIXED_PRIO_EN  defined: port0 always beats port1.
//                                        undefined: round-robin.
// ---------------------------------------------------------------------------
module ahb_matrix_output_arb (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        sel_op0,
    input  logic        sel_op1,
    input  logic [31:0] addr_op0,
    input  logic [31:0] addr_op1,
    input  logic [1:0]  trans_op0,
    input  logic [1:0]  trans_op1,
    input  logic        write_op0,
    input  logic        write_op1,
    input  logic [2:0]  size_op0,
    input  logic [2:0]  size_op1,
    input  logic [2:0]  burst_op0,
    input  logic [2:0]  burst_op1,
    input  logic [3:0]  prot_op0,
    input  logic [3:0]  prot_op1,
    input  logic [31:0] wdata_op0,
    input  logic [31:0] wdata_op1,
    input  logic        HREADYOUTM,
    output logic        active_op0,
    output logic        active_op1,
    output logic        HSELM,
    output logic [31:0] HADDRM,
    output logic [1:0]  HTRANSM,
    output logic        HWRITEM,
    output logic [2:0]  HSIZEM,
    output logic [2:0]  HBURSTM,
    output logic [3:0]  HPROTM,
    output logic [31:0] HWDATAM,
    output logic        HREADYMUXM
);

    localparam int unsigned BEAT_W = 4;

    localparam logic [1:0] PORT0 = 2'b00;
    localparam logic [1:0] PORT1 = 2'b01;
    localparam logic [1:0] NONE  = 2'b11;

    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BU_SINGLE = 3'b000;
    localparam logic [2:0] BU_INCR   = 3'b001;

    logic [1:0]        r_addr_port;
    logic [1:0]        r_data_port;
    logic [BEAT_W-1:0] r_beats;
    logic [1:0]        w_next_port;
    logic              w_req0;
    logic              w_req1;
    logic              w_acc;
    logic              w_acc_ns;
    logic              w_lock;
    logic [BEAT_W-1:0] w_len_m1;

    // Address/control mux from the current address-phase owner
    always_comb begin
        HSELM   = 1'b0;
        HADDRM  = 32'd0;
        HTRANSM = 2'b00;
        HWRITEM = 1'b0;
        HSIZEM  = 3'd0;
        HBURSTM = 3'd0;
        HPROTM  = 4'd0;
        case (r_addr_port)
            PORT0: begin
                HSELM   = sel_op0;
                HADDRM  = addr_op0;
                HTRANSM = trans_op0;
                HWRITEM = write_op0;
                HSIZEM  = size_op0;
                HBURSTM = burst_op0;
                HPROTM  = prot_op0;
            end
            PORT1: begin
                HSELM   = sel_op1;
                HADDRM  = addr_op1;
                HTRANSM = trans_op1;
                HWRITEM = write_op1;
                HSIZEM  = size_op1;
                HBURSTM = burst_op1;
                HPROTM  = prot_op1;
            end
            default: ;
        endcase
    end

    // Write data follows the data-phase owner
    always_comb begin
        HWDATAM = 32'd0;
        case (r_data_port)
            PORT0:   HWDATAM = wdata_op0;
            PORT1:   HWDATAM = wdata_op1;
            default: ;
        endcase
    end

    assign active_op0 = (r_addr_port == PORT0);
    assign active_op1 = (r_addr_port == PORT1);
    assign HREADYMUXM = HREADYOUTM;

    assign w_req0   = sel_op0 & trans_op0[1];
    assign w_req1   = sel_op1 & trans_op1[1];
    assign w_acc    = HREADYOUTM & (r_addr_port != NONE);
    assign w_acc_ns = w_acc & (HTRANSM == TR_NONSEQ);

    // Remaining SEQ beats after the NONSEQ of a fixed-length burst
    always_comb begin
        case (HBURSTM)
            3'b010, 3'b011: w_len_m1 = BEAT_W'(3);
            3'b100, 3'b101: w_len_m1 = BEAT_W'(7);
            3'b110, 3'b111: w_len_m1 = BEAT_W'(15);
            default:        w_len_m1 = BEAT_W'(0);
        endcase
    end

    // Burst lock. The owner's next SEQ is not visible while its NONSEQ is on
    // the bus, so a burst NONSEQ already holds the grant; a fixed-length burst
    // releases on its final SEQ so the other port gets the very next slot.
    always_comb begin
        w_lock = 1'b0;
        if ((r_addr_port != NONE) && HSELM) begin
            case (HTRANSM)
                TR_BUSY:   w_lock = 1'b1;
                TR_NONSEQ: w_lock = (HBURSTM != BU_SINGLE);
                TR_SEQ:    w_lock = (HBURSTM == BU_INCR) || (r_beats > BEAT_W'(1));
                default:   w_lock = 1'b0;
            endcase
        end
    end

`ifdef AHB_MATRIX_OUTPUT_ARB_FIXED_PRIO_EN
    // Fixed priority: port0 first
    always_comb begin
        w_next_port = NONE;
        if (w_lock)      w_next_port = r_addr_port;
        else if (w_req0) w_next_port = PORT0;
        else if (w_req1) w_next_port = PORT1;
    end
`else
    logic r_last_grant;   // 1: port1 was granted last
    logic w_last;

    // A NONSEQ accepted this cycle already counts as the latest grant
    assign w_last = w_acc_ns ? r_addr_port[0] : r_last_grant;

    // Round-robin: on contention the port not granted last wins
    always_comb begin
        w_next_port = NONE;
        if (w_lock)                w_next_port = r_addr_port;
        else if (w_req0 && w_req1) w_next_port = w_last ? PORT0 : PORT1;
        else if (w_req0)           w_next_port = PORT0;
        else if (w_req1)           w_next_port = PORT1;
    end

    // Last-granted port, updated on each accepted NONSEQ
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_last_grant <= 1'b1;
        end else if (w_acc_ns) begin
            r_last_grant <= r_addr_port[0];
        end
    end
`endif

    // Address/data phase owners and burst beat counter
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr_port <= NONE;
            r_data_port <= NONE;
            r_beats     <= '0;
        end else if (HREADYOUTM) begin
            r_addr_port <= w_next_port;
            r_data_port <= r_addr_port;
            if (w_acc && HSELM) begin
                if (HTRANSM == TR_NONSEQ) begin
                    r_beats <= w_len_m1;
                end else if ((HTRANSM == TR_SEQ) && (r_beats != '0)) begin
                    r_beats <= r_beats - BEAT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_matrix_output_arb.sv
// ---------------------------------------------------------------------------
// tb_ahb_matrix_output_arb
// Directed bench for the 2-port AHB output arbiter: reset values, idle bus,
// round-robin (or fixed priority), burst lock, wait states, write data
// steering and reset in the middle of a burst.
// ---------------------------------------------------------------------------
module tb_ahb_matrix_output_arb;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;
    localparam logic [2:0] SINGLE = 3'b000;
    localparam logic [2:0] INCR4  = 3'b011;

    logic        HCLK;
    logic        HRESETn;
    logic        sel_op0, sel_op1;
    logic [31:0] addr_op0, addr_op1;
    logic [1:0]  trans_op0, trans_op1;
    logic        write_op0, write_op1;
    logic [2:0]  size_op0, size_op1;
    logic [2:0]  burst_op0, burst_op1;
    logic [3:0]  prot_op0, prot_op1;
    logic [31:0] wdata_op0, wdata_op1;
    logic        HREADYOUTM;
    logic        active_op0, active_op1;
    logic        HSELM;
    logic [31:0] HADDRM;
    logic [1:0]  HTRANSM;
    logic        HWRITEM;
    logic [2:0]  HSIZEM;
    logic [2:0]  HBURSTM;
    logic [3:0]  HPROTM;
    logic [31:0] HWDATAM;
    logic        HREADYMUXM;

    int n_checks = 0;
    int n_errors = 0;

    ahb_matrix_output_arb dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .sel_op0    (sel_op0),
        .sel_op1    (sel_op1),
        .addr_op0   (addr_op0),
        .addr_op1   (addr_op1),
        .trans_op0  (trans_op0),
        .trans_op1  (trans_op1),
        .write_op0  (write_op0),
        .write_op1  (write_op1),
        .size_op0   (size_op0),
        .size_op1   (size_op1),
        .burst_op0  (burst_op0),
        .burst_op1  (burst_op1),
        .prot_op0   (prot_op0),
        .prot_op1   (prot_op1),
        .wdata_op0  (wdata_op0),
        .wdata_op1  (wdata_op1),
        .HREADYOUTM (HREADYOUTM),
        .active_op0 (active_op0),
        .active_op1 (active_op1),
        .HSELM      (HSELM),
        .HADDRM     (HADDRM),
        .HTRANSM    (HTRANSM),
        .HWRITEM    (HWRITEM),
        .HSIZEM     (HSIZEM),
        .HBURSTM    (HBURSTM),
        .HPROTM     (HPROTM),
        .HWDATAM    (HWDATAM),
        .HREADYMUXM (HREADYMUXM)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drv0(input logic s, input logic [1:0] t, input logic [31:0] a,
                        input logic [2:0] b, input logic w);
        sel_op0 = s; trans_op0 = t; addr_op0 = a; burst_op0 = b; write_op0 = w;
    endtask

    task automatic drv1(input logic s, input logic [1:0] t, input logic [31:0] a,
                        input logic [2:0] b, input logic w);
        sel_op1 = s; trans_op1 = t; addr_op1 = a; burst_op1 = b; write_op1 = w;
    endtask

    function automatic logic [31:0] act();
        return {30'd0, active_op0, active_op1};
    endfunction

    initial begin
        HRESETn    = 1'b0;
        HREADYOUTM = 1'b1;
        size_op0 = 3'b010; size_op1 = 3'b010;
        prot_op0 = 4'b0011; prot_op1 = 4'b0011;
        wdata_op0 = 32'h1111_1111; wdata_op1 = 32'h2222_2222;
        // Requests during reset must not reach the slave
        drv0(1'b1, NONSEQ, 32'h99, SINGLE, 1'b0);
        drv1(1'b1, NONSEQ, 32'h98, SINGLE, 1'b0);
        tick(); tick();
        #1;
        chk("rst_sel",   32'(HSELM), 32'd0);
        chk("rst_trans", 32'(HTRANSM), 32'd0);
        chk("rst_addr",  HADDRM, 32'd0);
        chk("rst_wdata", HWDATAM, 32'd0);
        chk("rst_act",   act(), 32'd0);
        tick();

        // Idle bus after reset release
        HRESETn = 1'b1;
        drv0(1'b0, IDLE, 32'h0, SINGLE, 1'b0);
        drv1(1'b0, IDLE, 32'h0, SINGLE, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("idle", {28'd0, HSELM, HTRANSM, active_op0 | active_op1}, 32'd0);
            tick();
        end
        chk("hready_mux1", 32'(HREADYMUXM), 32'd1);
        HREADYOUTM = 1'b0;
        #1 chk("hready_mux0", 32'(HREADYMUXM), 32'd0);
        HREADYOUTM = 1'b1;
        tick();

        // Simultaneous NONSEQ: port0 first, then arbitration policy
        drv0(1'b1, NONSEQ, 32'h10, SINGLE, 1'b0);
        drv1(1'b1, NONSEQ, 32'h20, SINGLE, 1'b0);
        #1 chk("lat_trans", 32'(HTRANSM), 32'd0);
        tick();
        #1;
        chk("c1_addr",  HADDRM, 32'h10);
        chk("c1_trans", 32'(HTRANSM), 32'(NONSEQ));
        chk("c1_sel",   32'(HSELM), 32'd1);
        chk("c1_act",   act(), 32'b10);
        tick();
        drv0(1'b1, NONSEQ, 32'h14, SINGLE, 1'b0);
        #1;
`ifdef AHB_MATRIX_OUTPUT_ARB_FIXED_PRIO_EN
        chk("c2_addr", HADDRM, 32'h14);
        chk("c2_act",  act(), 32'b10);
`else
        chk("c2_addr", HADDRM, 32'h20);
        chk("c2_act",  act(), 32'b01);
`endif
        tick();
        drv0(1'b0, IDLE, 32'h0, SINGLE, 1'b0);
        drv1(1'b0, IDLE, 32'h0, SINGLE, 1'b0);
        tick(); tick();
        #1 chk("park_none", act(), 32'd0);

        // INCR4 on port0 with port1 waiting
        drv0(1'b1, NONSEQ, 32'h100, INCR4, 1'b0);
        drv1(1'b1, NONSEQ, 32'h200, SINGLE, 1'b0);
        tick();
        #1;
        chk("b1_addr",  HADDRM, 32'h100);
        chk("b1_trans", 32'(HTRANSM), 32'(NONSEQ));
        tick();
        for (int b = 1; b < 4; b++) begin
            drv0(1'b1, SEQ, 32'h100 + 32'(4 * b), INCR4, 1'b0);
            #1;
            chk("bseq_addr", HADDRM, 32'h100 + 32'(4 * b));
            chk("bseq_act",  act(), 32'b10);
            tick();
        end
        drv0(1'b0, IDLE, 32'h0, SINGLE, 1'b0);
`ifdef AHB_MATRIX_OUTPUT_ARB_FIXED_PRIO_EN
        #1 chk("b5_park", act(), 32'b10);
        tick();
`endif
        #1;
        chk("b5_addr",  HADDRM, 32'h200);
        chk("b5_act",   act(), 32'b01);
        chk("b5_trans", 32'(HTRANSM), 32'(NONSEQ));
        tick();
        drv1(1'b0, IDLE, 32'h0, SINGLE, 1'b0);
        tick(); tick();

        // Wait states during port0 data phase freeze everything
        drv0(1'b1, NONSEQ, 32'h300, SINGLE, 1'b1);
        tick();
        #1 chk("ws_addr", HADDRM, 32'h300);
        tick();
        drv0(1'b1, IDLE, 32'h304, SINGLE, 1'b0);
        drv1(1'b1, NONSEQ, 32'h400, SINGLE, 1'b1);
        wdata_op0  = 32'hDEAD_0300;
        HREADYOUTM = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ws_hold_addr",  HADDRM, 32'h304);
            chk("ws_hold_act",   act(), 32'b10);
            chk("ws_hold_wdata", HWDATAM, 32'hDEAD_0300);
            tick();
        end
        HREADYOUTM = 1'b1;
        #1 chk("ws_rel_act", act(), 32'b10);
        tick();
        drv0(1'b1, NONSEQ, 32'h500, SINGLE, 1'b0);
        #1;
        chk("sw_addr",  HADDRM, 32'h400);
        chk("sw_act",   act(), 32'b01);
        chk("sw_wdata", HWDATAM, 32'hDEAD_0300);
        chk("sw_write", 32'(HWRITEM), 32'd1);
        tick();

        // Port1 write data steered while port0 owns the address phase
        wdata_op1 = 32'hA5A5_0001;
        drv1(1'b0, IDLE, 32'h0, SINGLE, 1'b0);
        #1;
        chk("wd_data", HWDATAM, 32'hA5A5_0001);
        chk("wd_addr", HADDRM, 32'h500);
        chk("wd_act",  act(), 32'b10);
        tick();
        drv0(1'b0, IDLE, 32'h0, SINGLE, 1'b0);
        tick(); tick();

        // Reset in the middle of a burst
        drv0(1'b1, NONSEQ, 32'h600, INCR4, 1'b0);
        tick();
        tick();
        drv0(1'b1, SEQ, 32'h604, INCR4, 1'b0);
        drv1(1'b1, NONSEQ, 32'h900, SINGLE, 1'b0);
        wdata_op0 = 32'h1234_5678;
        #1 chk("mb_addr", HADDRM, 32'h604);
        HRESETn = 1'b0;
        #1;
        chk("mrst_sel",   32'(HSELM), 32'd0);
        chk("mrst_trans", 32'(HTRANSM), 32'd0);
        chk("mrst_addr",  HADDRM, 32'd0);
        chk("mrst_wdata", HWDATAM, 32'd0);
        chk("mrst_act",   act(), 32'd0);
        tick(); tick();
        HRESETn = 1'b1;
        drv0(1'b1, NONSEQ, 32'h700, SINGLE, 1'b0);
        drv1(1'b1, NONSEQ, 32'h800, SINGLE, 1'b0);
        #1 chk("pr_lat", 32'(HTRANSM), 32'd0);
        tick();
        #1;
        chk("pr_addr", HADDRM, 32'h700);
        chk("pr_act",  act(), 32'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
